uart: RTL and testbench

Full-duplex 8N1 UART serving as the line follower's serial command link. A transmitter serializes a byte on `trmt`. A receiver deserializes a byte from `RX` and presents it on `cmd` with a `rdy` flag that the command processor clears through `clr_rdy`. Both halves run at a fixed bit period of `BAUD_CYCLES` system clocks: 2604 clocks at 50 MHz, which is 19200 baud.

---
 rtl/uart.sv | 147 ++++++++++++++
 tb/tb_uart.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart.sv
// Full-duplex 8N1 UART: byte transmitter driven by trmt, and a receiver
// that presents each good frame on cmd with a rdy flag.
module uart #(
    parameter int BAUD_CYCLES = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] cmd
);

    localparam int CW = (BAUD_CYCLES > 2) ? $clog2(BAUD_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;

    // ---------------- transmitter ----------------
    logic [0:0]    tx_state;
    logic [9:0]    tx_sr;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;

    // The register refills with ones, so its LSB doubles as the idle-high line.
    assign TX = tx_sr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_sr    <= '1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_sr    <= {1'b1, tx_data, 1'b0};
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        tx_done  <= 1'b0;
                        tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud <= '0;
                        tx_sr   <= {1'b1, tx_sr[9:1]};
                        tx_bit  <= tx_bit + 4'd1;
                        if (tx_bit == 4'd9) begin
                            tx_state <= TX_IDLE;
                            tx_done  <= 1'b1;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    rx_state;
    logic [8:0]    rx_sr;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_sr    <= '0;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rdy      <= 1'b0;
            cmd      <= 8'h00;
        end else begin
            if (clr_rdy)
                rdy <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_baud  <= '0;
                    end
                end
                RX_START: begin
                    if (rx_baud == HALF_LAST) begin
                        rx_baud <= '0;
                        if (!rx_sync) begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                            rdy      <= 1'b0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud <= '0;
                        rx_sr   <= {rx_sync, rx_sr[8:1]};
                        rx_bit  <= rx_bit + 4'd1;
                        // Ninth sample is the stop bit; rx_sr[8:1] holds the data byte.
                        if (rx_bit == 4'd8) begin
                            rx_state <= RX_IDLE;
                            if (rx_sync) begin
                                cmd <= rx_sr[8:1];
                                rdy <= 1'b1;
                            end
                        end
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: reset, TX bit timing, loopback, false start,
// framing error, back-to-back frames and mid-frame reset.
module tb_uart;

    localparam int B = 16;

    logic       clk, rst_n, trmt, clr_rdy, rx_drv, loop;
    logic [7:0] tx_data;
    logic       TX, tx_done, rdy, rx_line;
    logic [7:0] cmd;
    int         n_assert = 0;
    int         n_fail   = 0;

    assign rx_line = loop ? TX : rx_drv;

    uart #(.BAUD_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
        .TX(TX), .tx_done(tx_done), .RX(rx_line), .clr_rdy(clr_rdy),
        .rdy(rdy), .cmd(cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_loop(input logic [7:0] b, input bit clr);
        @(negedge clk);
        tx_data = b;
        trmt    = 1'b1;
        repeat (10) @(negedge clk);
        trmt = 1'b0;
        repeat (10 * B + 20) @(negedge clk);
        chk("loop_rdy", rdy, 1'b1);
        chk("loop_cmd", cmd, b);
        chk("loop_tx_done", tx_done, 1'b1);
        if (clr) begin
            clr_rdy = 1'b1;
            repeat (5) @(negedge clk);
            chk("clr_rdy", rdy, 1'b0);
            chk("clr_cmd", cmd, b);
            clr_rdy = 1'b0;
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_drv = bits[i];
            repeat (B - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] frame;
        rst_n = 1'b0; trmt = 1'b0; tx_data = 8'h00; clr_rdy = 1'b0;
        rx_drv = 1'b1; loop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("reset_TX", TX, 1'b1);
        chk("reset_rdy", rdy, 1'b0);
        chk("reset_cmd", cmd, 8'h00);
        chk("reset_tx_done", tx_done, 1'b0);

        // 0xA5 on the wire: 0,1,0,1,0,0,1,0,1,1, each bit B cycles
        frame = 10'b11_0100_1010;
        @(negedge clk);
        tx_data = 8'hA5;
        trmt    = 1'b1;
        @(posedge clk);
        #1;
        trmt    = 1'b0;
        tx_data = 8'h00;
        for (int k = 0; k < 10 * B; k++) begin
            chk("a5_TX", TX, frame[k / B]);
            chk("a5_done_low", tx_done, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("a5_done_high", tx_done, 1'b1);
        chk("a5_TX_idle", TX, 1'b1);

        // loopback, rdy left set between frames
        loop = 1'b1;
        send_loop(8'h00, 1'b0);
        send_loop(8'hFF, 1'b0);
        send_loop(8'h55, 1'b0);
        // loopback with clr_rdy after each byte
        send_loop(8'hA5, 1'b1);
        send_loop(8'h81, 1'b1);
        send_loop(8'hFE, 1'b1);
        loop = 1'b0;
        repeat (B) @(negedge clk);

        // false start
        rx_drv = 1'b0;
        repeat (B / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * B) @(negedge clk);
        chk("false_rdy", rdy, 1'b0);
        chk("false_cmd", cmd, 8'hFE);
        rx_frame(8'h3C, 1'b1);
        repeat (2 * B) @(negedge clk);
        chk("after_false_rdy", rdy, 1'b1);
        chk("after_false_cmd", cmd, 8'h3C);

        // framing error
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        rx_frame(8'h99, 1'b0);
        repeat (2 * B) @(negedge clk);
        chk("frame_err_rdy", rdy, 1'b0);
        chk("frame_err_cmd", cmd, 8'h3C);

        // back-to-back frames
        rx_frame(8'h12, 1'b1);
        rx_frame(8'h34, 1'b1);
        repeat (2 * B) @(negedge clk);
        chk("b2b_rdy", rdy, 1'b1);
        chk("b2b_cmd", cmd, 8'h34);

        // reset mid-frame aborts at once
        loop = 1'b1;
        @(negedge clk);
        tx_data = 8'h00;
        trmt    = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (3 * B) @(negedge clk);
        chk("mid_TX_low", TX, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_TX", TX, 1'b1);
        chk("mid_rst_rdy", rdy, 1'b0);
        chk("mid_rst_cmd", cmd, 8'h00);
        chk("mid_rst_done", tx_done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (12 * B) @(negedge clk);
        chk("post_rst_rdy", rdy, 1'b0);
        chk("post_rst_TX", TX, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
